// File: rtl/fifo_credit_based_pkg.sv
// Shared router constants for the credit-based flow-control loop.
// Buffer depth and upstream credit reset value must stay consistent.
package fifo_credit_based_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH     = 4;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;
    // One slack slot: upstream counter starts one below the depth.
    localparam logic [1:0] CREDIT_RST = 2'(FIFO_DEPTH - 1);
endpackage

// File: rtl/fifo_credit_based_storage.sv
// Register array with one write port and an asynchronous read port.
// Left unreset: contents are only observed behind the occupancy count.
module fifo_storage
    import fifo_credit_based_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_credit_based.sv
// Input-port flit buffer; returns one credit upstream per departed flit.
// Fall-through head: a flit written at an edge is visible right after it.
module fifo_credit_based
    import fifo_credit_based_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  valid_in,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty_out,
    output logic                  credit_out,
    output logic                  err_overflow,
    output logic                  err_multi_read
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          credit_q, credit_d;
    logic          ovf_q, ovf_d;
    logic          multi_q, multi_d;

    logic [4:0] read_vec;
    logic       read_req;
    logic       pop;
    logic       push;
    logic       full;

    assign read_vec = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
    assign read_req = |read_vec;
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = read_req & (count_q != '0);
    assign push     = valid_in & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        credit_d = pop;
        ovf_d    = ovf_q;
        multi_d  = multi_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (valid_in && full && !pop) begin
            ovf_d = 1'b1;
        end
        // Any two or more grants in one cycle; still only one pop.
        if ((read_vec & (read_vec - 5'd1)) != '0) begin
            multi_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
            multi_q  <= multi_d;
        end
    end

    fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (RX),
        .raddr (rd_ptr_q),
        .rdata (Data_out)
    );

    assign empty_out      = (count_q == '0);
    assign credit_out     = credit_q;
    assign err_overflow   = ovf_q;
    assign err_multi_read = multi_q;
endmodule

// File: tb/tb_fifo_credit_based.sv
// Directed bench for the credit-producing input buffer.
module tb_fifo_credit_based;
    logic        clk;
    logic        reset;
    logic [31:0] RX;
    logic        valid_in;
    logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
    logic [31:0] Data_out;
    logic        empty_out, credit_out, err_overflow, err_multi_read;

    int tests;
    int fails;

    fifo_credit_based dut (
        .clk            (clk),
        .reset          (reset),
        .RX             (RX),
        .valid_in       (valid_in),
        .read_en_N      (read_en_N),
        .read_en_E      (read_en_E),
        .read_en_W      (read_en_W),
        .read_en_S      (read_en_S),
        .read_en_L      (read_en_L),
        .Data_out       (Data_out),
        .empty_out      (empty_out),
        .credit_out     (credit_out),
        .err_overflow   (err_overflow),
        .err_multi_read (err_multi_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in  = 1'b0;
        RX        = '0;
        read_en_N = 1'b0;
        read_en_E = 1'b0;
        read_en_W = 1'b0;
        read_en_S = 1'b0;
        read_en_L = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (empty_out !== 1'b1 || credit_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: empty=%b credit=%b want 1 0", empty_out, credit_out);
        end
        tests++;
        if (err_overflow !== 1'b0 || err_multi_read !== 1'b0) begin
            fails++;
            $display("FAIL reset_err: ovf=%b multi=%b want 0 0", err_overflow, err_multi_read);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (credit_out !== 1'b0) begin
                fails++;
                $display("FAIL idle_credit[%0d]: got %b want 0", i, credit_out);
            end
        end
        read_en_E = 1'b1;
        tick();
        read_en_E = 1'b0;
        tick();
        tests++;
        if (credit_out !== 1'b0 || empty_out !== 1'b1) begin
            fails++;
            $display("FAIL empty_read: credit=%b empty=%b want 0 1", credit_out, empty_out);
        end
    endtask

    task automatic test_order();
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            RX = 32'hA1 + i;
            tick();
            tests++;
            if (empty_out !== 1'b0 || Data_out !== 32'hA1) begin
                fails++;
                $display("FAIL order_fill[%0d]: data=%h empty=%b want a1 0", i, Data_out, empty_out);
            end
        end
        idle_inputs();
        read_en_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 32'hA1 + i;
            tests++;
            if (Data_out !== exp) begin
                fails++;
                $display("FAIL order_data[%0d]: got %h want %h", i, Data_out, exp);
            end
            tick();
            tests++;
            if (credit_out !== 1'b1) begin
                fails++;
                $display("FAIL order_credit[%0d]: got %b want 1", i, credit_out);
            end
        end
        read_en_E = 1'b0;
        tests++;
        if (empty_out !== 1'b1) begin
            fails++;
            $display("FAIL order_empty: got %b want 1", empty_out);
        end
        tick();
        tests++;
        if (credit_out !== 1'b0) begin
            fails++;
            $display("FAIL order_credit_end: got %b want 0", credit_out);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        int credits;
        credits = 0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            RX = 32'hC0 + i;
            tick();
        end
        RX = 32'hFF;
        tick();
        idle_inputs();
        tests++;
        if (err_overflow !== 1'b1 || Data_out !== 32'hC0) begin
            fails++;
            $display("FAIL ovf_flag: ovf=%b data=%h want 1 c0", err_overflow, Data_out);
        end
        read_en_W = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 32'hC0 + i;
            tests++;
            if (Data_out !== exp || empty_out !== 1'b0) begin
                fails++;
                $display("FAIL ovf_data[%0d]: got %h empty=%b want %h 0", i, Data_out, empty_out, exp);
            end
            tick();
            if (credit_out) credits++;
        end
        read_en_W = 1'b0;
        tick();
        if (credit_out) credits++;
        tests++;
        if (empty_out !== 1'b1 || credits != 4 || err_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drain: empty=%b credits=%0d ovf=%b want 1 4 1", empty_out, credits, err_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [5];
        int credits;
        exp = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hB5};
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            RX = exp[i];
            tick();
        end
        RX = 32'hB5;
        read_en_N = 1'b1;
        tick();
        valid_in = 1'b0;
        tests++;
        if (credit_out !== 1'b1 || Data_out !== 32'hD1) begin
            fails++;
            $display("FAIL full_pp: credit=%b data=%h want 1 d1", credit_out, Data_out);
        end
        credits = 0;
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (Data_out !== exp[i] || empty_out !== 1'b0) begin
                fails++;
                $display("FAIL full_pp_data[%0d]: got %h empty=%b want %h 0", i, Data_out, empty_out, exp[i]);
            end
            tick();
            if (credit_out) credits++;
        end
        read_en_N = 1'b0;
        tests++;
        if (empty_out !== 1'b1 || credits != 4) begin
            fails++;
            $display("FAIL full_pp_drain: empty=%b credits=%0d want 1 4", empty_out, credits);
        end
        tick();
    endtask

    task automatic test_multi_read();
        valid_in = 1'b1;
        RX = 32'hE0;
        tick();
        RX = 32'hE1;
        tick();
        idle_inputs();
        tests++;
        if (err_multi_read !== 1'b0) begin
            fails++;
            $display("FAIL multi_pre: got %b want 0", err_multi_read);
        end
        read_en_L = 1'b1;
        read_en_S = 1'b1;
        tick();
        idle_inputs();
        tests++;
        if (err_multi_read !== 1'b1 || credit_out !== 1'b1 || Data_out !== 32'hE1 || empty_out !== 1'b0) begin
            fails++;
            $display("FAIL multi_pop: multi=%b credit=%b data=%h empty=%b want 1 1 e1 0",
                     err_multi_read, credit_out, Data_out, empty_out);
        end
        tick();
        tests++;
        if (credit_out !== 1'b0 || Data_out !== 32'hE1 || empty_out !== 1'b0) begin
            fails++;
            $display("FAIL multi_single: credit=%b data=%h empty=%b want 0 e1 0", credit_out, Data_out, empty_out);
        end
        read_en_L = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] exp;
        int credits;
        int bad;
        credits = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            valid_in  = (i < 6);
            RX        = 32'hF0 + i;
            read_en_W = (i >= 2);
            if (i >= 2) begin
                exp = 32'hF0 + (i - 2);
                tests++;
                if (Data_out !== exp) begin
                    fails++;
                    bad++;
                    $display("FAIL wrap_data[%0d]: got %h want %h", i, Data_out, exp);
                end
            end
            tick();
            if (credit_out) credits++;
        end
        idle_inputs();
        tick();
        if (credit_out) credits++;
        tests++;
        if (credits != 6 || empty_out !== 1'b1) begin
            fails++;
            $display("FAIL wrap_credits: credits=%0d empty=%b want 6 1", credits, empty_out);
        end
        valid_in = 1'b1;
        RX = 32'h11;
        tick();
        RX = 32'h22;
        tick();
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (empty_out !== 1'b1 || credit_out !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: empty=%b credit=%b want 1 0", empty_out, credit_out);
        end
        credits = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (credit_out) credits++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (credit_out) credits++;
        end
        tests++;
        if (credits != 0 || empty_out !== 1'b1) begin
            fails++;
            $display("FAIL post_reset: credits=%0d empty=%b want 0 1", credits, empty_out);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_multi_read();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_credit_based.md
# fifo_credit_based

Input-port flit buffer for the credit-based router. It is the credit-producing end of the flow-control loop: it accepts flits from the upstream link and holds them for the crossbar. Each time the local allocator grants a buffered flit and it leaves, the block returns exactly one credit pulse upstream. One instance sits on each of the N/E/W/S/L input ports; its `empty_out` feeds the allocator's `empty_X` input.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width in bits
- DEPTH, 4, buffer slots; fixed at 4 because the upstream 2-bit credit counter resets to 3 (one slack slot)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when 0
- RX  in  DATA_WIDTH  incoming flit
- valid_in  in  1  RX holds a flit to be written this cycle
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  in  1 each  allocator grants toward this input port; at most one is high per cycle
- Data_out  out  DATA_WIDTH  head flit; valid only while empty_out=0
- empty_out  out  1  buffer holds no flits
- credit_out  out  1  one-cycle credit pulse to the upstream counter
- err_overflow  out  1  sticky: a write arrived while the buffer was full and no read occurred
- err_multi_read  out  1  sticky: more than one read_en was high in the same cycle

## Operation
- State:
  - DEPTH x DATA_WIDTH storage
  - write pointer and read pointer, each clog2(DEPTH) bits, wrapping modulo DEPTH
  - occupancy count, clog2(DEPTH)+1 bits, range 0..DEPTH
  - credit_out register and both error flags
- read_req = OR of the five read_en inputs.
- pop = read_req & (count != 0).
- push = valid_in & ((count != DEPTH) | pop).
- On push: storage[wr_ptr] <= RX; wr_ptr advances by 1.
- On pop: rd_ptr advances by 1.
- Count update: push only -> +1; pop only -> -1; both or neither -> unchanged.
- Data_out = storage[rd_ptr], combinational (fall-through). empty_out = (count == 0).
- credit_out <= pop, registered. There is exactly one credit per departed flit; a read on an empty buffer returns none.
- Write while full with no pop: the flit is dropped, no state change, err_overflow <= 1.
- err_multi_read <= 1 when two or more read_en inputs are high. Exactly one pop still occurs.
- Error flags clear only on reset.

## Timing
- Reset values: pointers 0, count 0, empty_out 1, credit_out 0, err_overflow 0, err_multi_read 0. Data_out is don't-care while empty.
- Write-to-visible latency: flit written at edge k appears on Data_out with empty_out=0 immediately after edge k. The allocator may grant it in cycle k+1.
- Pop at edge k -> credit_out high for the cycle after edge k (edge k to edge k+1), then low unless another pop occurs. Back-to-back pops give credit_out high on consecutive cycles.
- Simultaneous push and pop:
  - at count=DEPTH: both are accepted, count stays DEPTH
  - at count=0: no pop occurs, the push is accepted
- Pointer wrap: index DEPTH-1 -> 0 with no bubble.
- Reset asserted mid-operation: all buffered flits are discarded and no credits are returned for them. The upstream counter is reset to full by the same reset.

## Structure
- Shared router package holds:
  - DATA_WIDTH default
  - DEPTH constant
  - pointer-width and count-width constants derived via clog2
  - credit reset value (DEPTH-1 = 3), so this block and the allocator's counters stay consistent
- One sub-module is natural: `fifo_storage`, a DEPTH x DATA_WIDTH register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). Pointer, count, credit and error logic stay in the top module.

## Test plan
- Reset then idle: empty_out=1, credit_out=0, both error flags 0; 10 idle cycles produce no credit.
- Write 0xA1,0xA2,0xA3 on consecutive cycles, then read_en_E for 3 cycles:
  - Data_out shows A1, A2, A3 in order
  - credit_out is high for 3 cycles, each lagging its pop by one cycle
  - empty_out returns to 1
- Fill 4 flits, then write 0xFF with no read: err_overflow=1, count stays 4, subsequent reads return the original 4 flits only.
- At full, push 0xB5 and read_en_N in the same cycle: count stays 4, one credit is returned, 0xB5 emerges after the 3 older flits.
- read_en_L and read_en_S high together with 2 flits buffered: one pop, err_multi_read=1, one credit.
- Push 6 flits interleaved with pops so both pointers wrap twice: output order matches input order, total credits = 6. Then assert reset with 2 flits held: empty_out=1 immediately, no credit pulse is issued.
